key_debounce_repeat: RTL and testbench

//  Conditions the raw set buttons (sec clear, min adjust, hour adjust) before they reach the

---
 rtl/key_debounce_repeat.sv | 155 +++++++++++++++
 tb/tb_key_debounce_repeat.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/key_debounce_repeat.sv
// ---------------------------------------------------------------------------
// key_debounce_repeat
//   Conditions raw push-button levels for the timer set logic. Each key has
//   its own path: a two-flop synchroniser, a stability debouncer, and a
//   press / hold / auto-repeat state machine. A held key pulses once on the
//   accepted press, again HOLD_CYC cycles later, and then every REPEAT_CYC
//   cycles until the release is accepted. All outputs are registered.
//
// Ports
//   clk        in   1         system clock, all logic on posedge
//   rst_n      in   1         synchronous active-low reset (clears everything)
//   key_in     in   NUM_KEYS  raw active-high button levels, asynchronous
//   key_level  out  NUM_KEYS  debounced key level
//   key_pulse  out  NUM_KEYS  one-cycle pulse on accepted press and repeats
//   key_long   out  NUM_KEYS  high while the key is auto-repeating
// ---------------------------------------------------------------------------
module key_debounce_repeat #(
  parameter int NUM_KEYS     = 3,
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int HOLD_CYC     = 100_000_000,
  parameter int REPEAT_CYC   = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HLD_W = (HOLD_CYC     > 1) ? $clog2(HOLD_CYC)     : 1;
  localparam int REP_W = (REPEAT_CYC   > 1) ? $clog2(REPEAT_CYC)   : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYC - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Two-flop synchroniser for the asynchronous button levels.
  logic [NUM_KEYS-1:0] sync_p0;
  logic [NUM_KEYS-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= key_in;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [DEB_W-1:0] deb_cnt;
    logic             rise_acc;
    logic             fall_acc;

    state_t           state;
    state_t           state_nxt;
    logic [HLD_W-1:0] hold_cnt;
    logic [HLD_W-1:0] hold_cnt_nxt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic             pulse_nxt;

    // A level change is accepted on the edge where it has been stable for
    // DEBOUNCE_CYC consecutive cycles; the FSM reacts on that same edge.
    assign rise_acc = (sync_p1[k] != key_level[k]) && (deb_cnt == DEB_LAST) &&  sync_p1[k];
    assign fall_acc = (sync_p1[k] != key_level[k]) && (deb_cnt == DEB_LAST) && !sync_p1[k];

    // Debounce stage: any cycle agreeing with the current level restarts
    // the count, so short glitches never reach key_level.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        deb_cnt      <= '0;
        key_level[k] <= 1'b0;
      end else if (sync_p1[k] != key_level[k]) begin
        if (deb_cnt == DEB_LAST) begin
          deb_cnt      <= '0;
          key_level[k] <= sync_p1[k];
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end

    // Press / hold / repeat next-state logic. An accepted release is
    // checked first so it beats a terminal count on the same edge.
    always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      rep_cnt_nxt  = rep_cnt;
      pulse_nxt    = 1'b0;
      unique case (state)
        IDLE: begin
          if (rise_acc) begin
            state_nxt    = PRESS;
            hold_cnt_nxt = '0;
            pulse_nxt    = 1'b1;
          end
        end
        PRESS: begin
          if (fall_acc) begin
            state_nxt = IDLE;
          end else if (hold_cnt == HLD_LAST) begin
            state_nxt   = REPEAT;
            rep_cnt_nxt = '0;
            pulse_nxt   = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (fall_acc) begin
            state_nxt = IDLE;
          end else if (rep_cnt == REP_LAST) begin
            rep_cnt_nxt = '0;
            pulse_nxt   = 1'b1;
          end else begin
            rep_cnt_nxt = rep_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state        <= IDLE;
        hold_cnt     <= '0;
        rep_cnt      <= '0;
        key_pulse[k] <= 1'b0;
        key_long[k]  <= 1'b0;
      end else begin
        state        <= state_nxt;
        hold_cnt     <= hold_cnt_nxt;
        rep_cnt      <= rep_cnt_nxt;
        key_pulse[k] <= pulse_nxt;
        key_long[k]  <= (state_nxt == REPEAT);
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_repeat
//   Directed bench for key_debounce_repeat with short timing parameters
//   (DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=5). Edge 1 of each scenario is
//   the first clock edge that samples the new key_in value. Every edge of
//   every scenario compares the full level/pulse/long vectors against
//   hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_key_debounce_repeat;

  localparam int NK = 3;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_pulse;
  logic [NK-1:0] key_long;

  int checks;
  int errors;
  int pulse_edges[$];

  key_debounce_repeat #(
    .NUM_KEYS    (NK),
    .DEBOUNCE_CYC(4),
    .HOLD_CYC    (20),
    .REPEAT_CYC  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_level(key_level),
    .key_pulse(key_pulse),
    .key_long (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int edge_no,
                     input logic [NK-1:0] obs, input logic [NK-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, edge_no, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive 'keys' from edge 1, drop them after edge hold_len, and check
  // n_edges edges. key_level is expected high on [rise_e, fall_e), key_long
  // on [long_s, long_e], and key_pulse on the edges listed in pulse_edges.
  task automatic run_case(input string tag, input logic [NK-1:0] keys,
                          input int hold_len, input int n_edges,
                          input int rise_e, input int fall_e,
                          input int long_s, input int long_e);
    logic [NK-1:0] e_lvl;
    logic [NK-1:0] e_pls;
    logic [NK-1:0] e_lng;
    key_in = keys;
    for (int e = 1; e <= n_edges; e++) begin
      tick();
      e_lvl = (e >= rise_e && e < fall_e) ? keys : '0;
      e_lng = (e >= long_s && e <= long_e) ? keys : '0;
      e_pls = '0;
      foreach (pulse_edges[i]) if (pulse_edges[i] == e) e_pls = keys;
      chk({tag, "_level"}, e, key_level, e_lvl);
      chk({tag, "_pulse"}, e, key_pulse, e_pls);
      chk({tag, "_long"},  e, key_long,  e_lng);
      if (e == hold_len) key_in = '0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    key_in = '0;

    // Reset state.
    tick();
    tick();
    chk("rst_level", 0, key_level, '0);
    chk("rst_pulse", 0, key_pulse, '0);
    chk("rst_long",  0, key_long,  '0);
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: single press on key 0, short hold, clean release without a pulse.
    pulse_edges = '{6};
    run_case("t1", 3'b001, 10, 20, 6, 16, 1000, 0);

    // 2: 3-cycle bounce on key 1 never gets accepted.
    pulse_edges = '{};
    run_case("t2", 3'b010, 3, 12, 1000, 0, 1000, 0);

    // 3: long hold on key 2, release accepted between repeats.
    pulse_edges = '{6, 26, 31, 36, 41};
    run_case("t3", 3'b100, 38, 50, 6, 44, 26, 43);

    // 4: release accepted on a repeat terminal-count edge (46): no pulse.
    pulse_edges = '{6, 26, 31, 36, 41};
    run_case("t4", 3'b100, 40, 52, 6, 46, 26, 45);

    // 5: keys 0 and 2 together pulse together.
    pulse_edges = '{6};
    run_case("t5", 3'b101, 10, 20, 6, 16, 1000, 0);

    // 6: key 1 held into repeat, reset sampled at edge 30.
    pulse_edges = '{6, 26};
    run_case("t6a", 3'b010, 1000, 29, 6, 1000, 26, 1000);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_level", 30, key_level, '0);
    chk("t6_rst_pulse", 30, key_pulse, '0);
    chk("t6_rst_long",  30, key_long,  '0);
    rst_n = 1'b1;
    // Synchronisers restart from 0, so the held key is re-accepted as a
    // fresh press six edges after the reset edge (edge 36).
    pulse_edges = '{6};
    run_case("t6b", 3'b010, 1000, 10, 6, 1000, 1000, 0);
    key_in = '0;
    repeat (8) tick();
    chk("t6_release_level", 0, key_level, '0);
    chk("t6_release_long",  0, key_long,  '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
